microsequencer: RTL and testbench

- Next-state address generator for the microprogrammed control unit.
- Consumes the next-state fields (N, inv, select, cr) that the control register drives, plus status inputs.
- Each cycle it registers the next 10-bit microstore address, which the control ROM turns into the 44-bit word the control register latches.
- Holds the incrementer register and a one-level microsubroutine return register.

---
 rtl/microsequencer.sv | 119 +++++++++++
 tb/tb_microsequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Next-state address generator for the microprogrammed control unit.
// Registers the next microstore address, its increment and a one-level return address.
module microsequencer #(
    parameter int unsigned STATE_W     = 10,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned FETCH_STATE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         N,
    input  logic               inv,
    input  logic [1:0]         select,
    input  logic [STATE_W-1:0] cr,
    input  logic [STATE_W-1:0] decoder_state,
    input  logic               moc,
    input  logic               cond,
    input  logic               ir_ready,
    output logic [STATE_W-1:0] current_state,
    output logic [STATE_W-1:0] incr_state,
    output logic [STATE_W-1:0] ret_state,
    output logic               ret_valid,
    output logic               stack_err
);

    localparam logic [STATE_W-1:0] L_RESET = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] L_FETCH = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] L_ONE   = STATE_W'(1);

    typedef enum logic [2:0] {
        N_DECODE = 3'b000,
        N_FETCH  = 3'b001,
        N_JUMP   = 3'b010,
        N_INCR   = 3'b011,
        N_BRANCH = 3'b100,
        N_WAIT   = 3'b101,
        N_CALL   = 3'b110,
        N_RETURN = 3'b111
    } n_mode_t;

    logic [STATE_W-1:0] r_current;
    logic [STATE_W-1:0] r_incr;
    logic [STATE_W-1:0] r_ret;
    logic               r_ret_valid;
    logic               r_stack_err;

    n_mode_t            w_mode;
    logic               w_sel;
    logic               w_c;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_ret_next;
    logic               w_ret_valid_next;
    logic               w_stack_err_next;

    assign w_mode = n_mode_t'(N);

    always_comb begin
        w_sel = 1'b1;
        case (select)
            2'b00:   w_sel = moc;
            2'b01:   w_sel = cond;
            2'b10:   w_sel = ir_ready;
            default: w_sel = 1'b1;
        endcase
        w_c = w_sel ^ inv;
    end

    always_comb begin
        w_next           = r_incr;
        w_ret_next       = r_ret;
        w_ret_valid_next = r_ret_valid;
        w_stack_err_next = r_stack_err;
        case (w_mode)
            N_DECODE: w_next = decoder_state;
            N_FETCH:  w_next = L_FETCH;
            N_JUMP:   w_next = cr;
            N_INCR:   w_next = r_incr;
            N_BRANCH: w_next = w_c ? cr : r_incr;
            // Holding current_state also leaves incr_state unchanged, since it is recomputed as next+1.
            N_WAIT:   w_next = w_c ? cr : r_current;
            N_CALL: begin
                w_next           = cr;
                w_ret_next       = r_incr;
                w_ret_valid_next = 1'b1;
            end
            N_RETURN: begin
                if (r_ret_valid) begin
                    w_next           = r_ret;
                    w_ret_valid_next = 1'b0;
                end else begin
                    w_next           = L_FETCH;
                    w_stack_err_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_current   <= L_RESET;
            r_incr      <= L_RESET + L_ONE;
            r_ret       <= '0;
            r_ret_valid <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_current   <= w_next;
            r_incr      <= w_next + L_ONE;
            r_ret       <= w_ret_next;
            r_ret_valid <= w_ret_valid_next;
            r_stack_err <= w_stack_err_next;
        end
    end

    assign current_state = r_current;
    assign incr_state    = r_incr;
    assign ret_state     = r_ret;
    assign ret_valid     = r_ret_valid;
    assign stack_err     = r_stack_err;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios plus random stimulus against
// an arithmetic reference model of the next-state rules.
module tb_microsequencer;

    localparam int unsigned W    = 10;
    localparam int unsigned MODV = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   N;
    logic         inv;
    logic [1:0]   select;
    logic [W-1:0] cr;
    logic [W-1:0] decoder_state;
    logic         moc;
    logic         cond;
    logic         ir_ready;
    logic [W-1:0] current_state;
    logic [W-1:0] incr_state;
    logic [W-1:0] ret_state;
    logic         ret_valid;
    logic         stack_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    int unsigned m_cur, m_incr, m_ret;
    bit          m_rv, m_err;

    microsequencer #(.STATE_W(W), .RESET_STATE(0), .FETCH_STATE(1)) dut (
        .clk(clk), .reset(reset), .N(N), .inv(inv), .select(select), .cr(cr),
        .decoder_state(decoder_state), .moc(moc), .cond(cond), .ir_ready(ir_ready),
        .current_state(current_state), .incr_state(incr_state),
        .ret_state(ret_state), .ret_valid(ret_valid), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int unsigned sel_v, c, nxt;
        if (reset) begin
            m_cur = 0; m_incr = 1; m_ret = 0; m_rv = 0; m_err = 0;
            return;
        end
        sel_v = (select == 0) ? moc : (select == 1) ? cond : (select == 2) ? ir_ready : 1;
        c = sel_v ^ inv;
        case (N)
            0: nxt = decoder_state;
            1: nxt = 1;
            2: nxt = cr;
            3: nxt = m_incr;
            4: nxt = c ? cr : m_incr;
            5: nxt = c ? cr : m_cur;
            6: begin nxt = cr; m_ret = m_incr; m_rv = 1; end
            default: begin
                if (m_rv) begin nxt = m_ret; m_rv = 0; end
                else begin nxt = 1; m_err = 1; end
            end
        endcase
        m_cur  = nxt;
        m_incr = (nxt + 1) % MODV;
    endtask

    task automatic apply(input bit rst, input int unsigned n, input bit iv, input int unsigned sel,
                         input int unsigned crv, input bit mc, input bit cd, input string tag);
        reset = rst; N = 3'(n); inv = iv; select = 2'(sel); cr = W'(crv);
        moc = mc; cond = cd;
        @(posedge clk);
        model_step();
        #1;
        check_eq({tag, ".cur"},  current_state, m_cur);
        check_eq({tag, ".incr"}, incr_state,    m_incr);
        check_eq({tag, ".ret"},  ret_state,     m_ret);
        check_eq({tag, ".rv"},   ret_valid,     m_rv);
        check_eq({tag, ".err"},  stack_err,     m_err);
    endtask

    task automatic goto_state(input int unsigned s);
        apply(0, 2, 0, 0, s, 0, 0, "goto");
    endtask

    initial begin
        reset = 1; N = 3'b010; inv = 0; select = 0; cr = '1;
        decoder_state = '0; moc = 0; cond = 0; ir_ready = 0;
        m_cur = 0; m_incr = 1; m_ret = 0; m_rv = 0; m_err = 0;
        @(negedge clk);

        apply(1, 2, 0, 0, 10'h3FF, 0, 0, "rst0");
        apply(1, 2, 0, 0, 10'h3FF, 0, 0, "rst1");
        check_eq("rst_cur_const", current_state, 0);
        check_eq("rst_incr_const", incr_state, 1);

        goto_state(5);
        apply(0, 3, 0, 0, 0, 0, 0, "seq6");
        apply(0, 3, 0, 0, 0, 0, 0, "seq7");
        apply(0, 3, 0, 0, 0, 0, 0, "seq8");
        check_eq("seq8_const", current_state, 8);
        decoder_state = 10'h040;
        apply(0, 0, 0, 0, 0, 0, 0, "dec");
        check_eq("dec_const", current_state, 10'h040);
        apply(0, 1, 0, 0, 0, 0, 0, "fetch");
        check_eq("fetch_const", current_state, 1);

        goto_state(20);
        apply(0, 4, 0, 1, 50, 0, 1, "br_taken");
        check_eq("br_taken_const", current_state, 50);
        goto_state(20);
        apply(0, 4, 1, 1, 50, 0, 1, "br_inv");
        check_eq("br_inv_const", current_state, 21);
        apply(0, 4, 1, 3, 99, 0, 0, "br_const0");

        goto_state(30);
        for (int i = 0; i < 4; i++) apply(0, 5, 0, 0, 31, 0, 0, "hold");
        check_eq("hold_const", current_state, 30);
        check_eq("hold_incr_const", incr_state, 31);
        apply(0, 5, 0, 0, 31, 1, 0, "hold_exit");
        check_eq("hold_exit_const", current_state, 31);

        goto_state(10);
        apply(0, 6, 0, 0, 200, 0, 0, "call");
        check_eq("call_ret_const", ret_state, 11);
        apply(0, 7, 0, 0, 0, 0, 0, "ret");
        check_eq("ret_cur_const", current_state, 11);
        apply(0, 7, 0, 0, 0, 0, 0, "ret_empty");
        check_eq("ret_empty_const", current_state, 1);
        apply(0, 3, 0, 0, 0, 0, 0, "err_sticky0");
        apply(0, 6, 0, 0, 77, 0, 0, "call_after_err");
        apply(0, 6, 0, 0, 88, 0, 0, "call_overwrite");
        check_eq("err_sticky_const", stack_err, 1);

        goto_state(10'h3FF);
        apply(0, 3, 0, 0, 0, 0, 0, "wrap");
        check_eq("wrap_const", current_state, 0);
        goto_state(30);
        apply(0, 5, 0, 0, 31, 0, 0, "hold_pre_rst");
        apply(1, 5, 0, 0, 31, 0, 0, "rst_in_hold");
        check_eq("rst_hold_const", current_state, 0);

        for (int i = 0; i < 400; i++) begin
            decoder_state = W'($urandom);
            ir_ready = 1'($urandom);
            apply(($urandom_range(0, 39) == 0), $urandom_range(0, 7), 1'($urandom),
                  $urandom_range(0, 3), $urandom, 1'($urandom), 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
